fpu_flag_checker: RTL and testbench

Synthesizable, parametrised exception-flag checker for the single-precision FPU. It sits beside the FPU on the same clock and samples each issued operation (opa, opb, fpu_op). It classifies IEEE-754 special-operand cases into an expected flag and tracks up to DEPTH outstanding operations, each with its own age counter. Each operation must see its expected flag within a programmable latency window; otherwise a violation is reported with its rule id and counted, so the checks run on hardware and in emulation, not only in simulation.

---
 rtl/fpu_flag_checker.sv | 164 ++++++++++++++++
 tb/tb_fpu_flag_checker.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_flag_checker.sv
// Exception-flag checker for the single-precision FPU: classifies special-operand
// operations, tracks them in aged slots and reports late/missing flags as violations.
module fpu_flag_checker #(
    parameter int unsigned WIN_MIN = 2,
    parameter int unsigned WIN_MAX = 10,
    parameter int unsigned DEPTH   = 12,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    input  logic [31:0]      opa,
    input  logic [31:0]      opb,
    input  logic [2:0]       fpu_op,
    input  logic [7:0]       flags,
    output logic             err_pulse,
    output logic [3:0]       err_rule,
    output logic             sticky_err,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] pass_count,
    output logic [CNT_W-1:0] drop_count,
    output logic             busy
);

    localparam int unsigned AGE_W = (WIN_MAX < 1) ? 1 : $clog2(WIN_MAX + 1);
    localparam int unsigned PN_W  = $clog2(DEPTH + 1);

    localparam logic [30:0] MAG_INF = 31'h7F80_0000;

    // Flag bit a rule expects: qnan=2, div_by_zero=7, inf=0, zero=6.
    function automatic logic [2:0] flag_idx(input logic [3:0] r);
        case (r)
            4'd1, 4'd3, 4'd4, 4'd6:  flag_idx = 3'd2;
            4'd2:                    flag_idx = 3'd7;
            4'd5, 4'd7, 4'd8, 4'd9:  flag_idx = 3'd0;
            default:                 flag_idx = 3'd6;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                                 input logic [CNT_W:0]   inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, cnt} + inc;
        sat_add = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    logic [DEPTH-1:0]            valid_q, valid_n;
    logic [DEPTH-1:0][3:0]       rule_q, rule_n;
    logic [DEPTH-1:0][AGE_W-1:0] age_q, age_n;

    logic [3:0]      rule_c;
    logic [PN_W-1:0] pass_num_c;
    logic            timeout_c, drop_c, placed_c, r13_c;
    logic [3:0]      to_rule_c;
    logic [1:0]      err_inc_c;

    // Operand classification into rule id (0 = nothing to check).
    always_comb begin
        logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_fin, b_fin;
        logic is_add_sub, is_mul, is_div, eff_sub;
        a_zero     = (opa[30:0] == 31'd0);
        b_zero     = (opb[30:0] == 31'd0);
        a_inf      = (opa[30:0] == MAG_INF);
        b_inf      = (opb[30:0] == MAG_INF);
        a_nan      = (opa[30:23] == 8'hFF) && (opa[22:0] != 23'd0);
        b_nan      = (opb[30:23] == 8'hFF) && (opb[22:0] != 23'd0);
        a_fin      = !a_inf && !a_nan;
        b_fin      = !b_inf && !b_nan;
        is_add_sub = (fpu_op == 3'd0) || (fpu_op == 3'd1);
        is_mul     = (fpu_op == 3'd2);
        is_div     = (fpu_op == 3'd3);
        eff_sub    = ((fpu_op == 3'd0) && (opa[31] != opb[31])) ||
                     ((fpu_op == 3'd1) && (opa[31] == opb[31]));
        rule_c = 4'd0;
        if (a_nan || b_nan)                                           rule_c = 4'd0;
        else if (is_div && a_zero && b_zero)                          rule_c = 4'd1;
        else if (is_div && b_zero)                                    rule_c = 4'd2;
        else if (is_mul && ((a_zero && b_inf) || (a_inf && b_zero)))  rule_c = 4'd3;
        else if (is_add_sub && a_inf && b_inf && eff_sub)             rule_c = 4'd4;
        else if (is_add_sub && a_inf && b_inf)                        rule_c = 4'd5;
        else if (is_div && a_inf && b_inf)                            rule_c = 4'd6;
        else if (is_add_sub && (a_inf != b_inf))                      rule_c = 4'd7;
        else if (is_mul && ((a_inf && b_fin && !b_zero) ||
                            (b_inf && a_fin && !a_zero)))             rule_c = 4'd8;
        else if (is_div && a_inf && b_fin)                            rule_c = 4'd9;
        else if (is_mul && ((a_zero && b_fin) || (b_zero && a_fin)))  rule_c = 4'd10;
        else if (is_div && a_zero && b_fin)                           rule_c = 4'd11;
        else if (is_add_sub && a_fin && b_fin && eff_sub &&
                 (opa[30:0] == opb[30:0]))                            rule_c = 4'd12;
    end

    // Slot aging, pass/timeout resolution and lowest-free-slot enqueue.
    always_comb begin
        valid_n    = valid_q;
        rule_n     = rule_q;
        age_n      = age_q;
        pass_num_c = '0;
        timeout_c  = 1'b0;
        to_rule_c  = 4'd0;
        placed_c   = 1'b0;
        drop_c     = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (valid_q[i]) begin
                if ((age_q[i] >= AGE_W'(WIN_MIN)) && flags[flag_idx(rule_q[i])]) begin
                    valid_n[i] = 1'b0;
                    pass_num_c = pass_num_c + PN_W'(1);
                end else if (age_q[i] == AGE_W'(WIN_MAX)) begin
                    valid_n[i] = 1'b0;
                    timeout_c  = 1'b1;
                    to_rule_c  = rule_q[i];
                end else begin
                    age_n[i] = age_q[i] + AGE_W'(1);
                end
            end
        end
        // Free slots are judged on the pre-retire state so a retiring slot is not reused.
        if (in_valid && en && (rule_c != 4'd0)) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (!placed_c && !valid_q[i]) begin
                    placed_c   = 1'b1;
                    valid_n[i] = 1'b1;
                    rule_n[i]  = rule_c;
                    age_n[i]   = AGE_W'(1);
                end
            end
            drop_c = !placed_c;
        end
    end

    assign r13_c     = flags[4] && flags[5];
    assign err_inc_c = 2'(timeout_c) + 2'(r13_c);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= '0;
            rule_q     <= '0;
            age_q      <= '0;
            err_pulse  <= 1'b0;
            err_rule   <= 4'd0;
            sticky_err <= 1'b0;
            err_count  <= '0;
            pass_count <= '0;
            drop_count <= '0;
            busy       <= 1'b0;
        end else begin
            valid_q    <= valid_n;
            rule_q     <= rule_n;
            age_q      <= age_n;
            err_pulse  <= timeout_c || r13_c;
            if (timeout_c)
                err_rule <= to_rule_c;
            else if (r13_c)
                err_rule <= 4'd13;
            if (timeout_c || r13_c)
                sticky_err <= 1'b1;
            err_count  <= sat_add(err_count, (CNT_W+1)'(err_inc_c));
            pass_count <= sat_add(pass_count, (CNT_W+1)'(pass_num_c));
            drop_count <= sat_add(drop_count, (CNT_W+1)'(drop_c));
            busy       <= |valid_n;
        end
    end

endmodule

// File: tb/tb_fpu_flag_checker.sv
// Directed bench for fpu_flag_checker: default instance plus a DEPTH=4, CNT_W=4 instance
// sharing the same stimulus for drop and saturation cases.
module tb_fpu_flag_checker;

    logic        clk_aux = 1'b0;
    logic        rst, en, in_valid;
    logic [31:0] opa, opb;
    logic [2:0]  fpu_op;
    logic [7:0]  flags;

    logic        a_err_pulse, a_sticky_err, a_busy;
    logic [3:0]  a_err_rule;
    logic [15:0] a_err_count, a_pass_count, a_drop_count;

    logic        b_err_pulse, b_sticky_err, b_busy;
    logic [3:0]  b_err_rule;
    logic [3:0]  b_err_count, b_pass_count, b_drop_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_aux = ~clk_aux;

    fpu_flag_checker u_dut_a (
        .clk(clk_aux), .rst(rst), .en(en), .in_valid(in_valid),
        .opa(opa), .opb(opb), .fpu_op(fpu_op), .flags(flags),
        .err_pulse(a_err_pulse), .err_rule(a_err_rule), .sticky_err(a_sticky_err),
        .err_count(a_err_count), .pass_count(a_pass_count), .drop_count(a_drop_count),
        .busy(a_busy)
    );

    fpu_flag_checker #(.WIN_MIN(2), .WIN_MAX(10), .DEPTH(4), .CNT_W(4)) u_dut_b (
        .clk(clk_aux), .rst(rst), .en(en), .in_valid(in_valid),
        .opa(opa), .opb(opb), .fpu_op(fpu_op), .flags(flags),
        .err_pulse(b_err_pulse), .err_rule(b_err_rule), .sticky_err(b_sticky_err),
        .err_count(b_err_count), .pass_count(b_pass_count), .drop_count(b_drop_count),
        .busy(b_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_aux);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        flags    = 8'h00;
        ticks(2);
        rst = 1'b0;
    endtask

    // Drives one operation, sampled on the next edge (issue cycle T).
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        fpu_op   = op;
        opa      = a;
        opb      = b;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        logic seen;
        rst = 1'b1; en = 1'b1; in_valid = 1'b0;
        opa = '0; opb = '0; fpu_op = 3'd0; flags = 8'h00;
        do_reset();

        check("reset_err_pulse", 32'(a_err_pulse), 0);
        check("reset_err_rule",  32'(a_err_rule), 0);
        check("reset_sticky",    32'(a_sticky_err), 0);
        check("reset_err_count", 32'(a_err_count), 0);
        check("reset_busy",      32'(a_busy), 0);

        // div 1.0/0 -> div_by_zero seen at age 3
        issue(3'd3, 32'h3F80_0000, 32'h0000_0000);
        check("r2_busy_after_issue", 32'(a_busy), 1);
        ticks(2);
        flags = 8'h80;
        tick();
        flags = 8'h00;
        check("r2_pass_count", 32'(a_pass_count), 1);
        check("r2_busy_low",   32'(a_busy), 0);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            seen = seen | a_err_pulse;
            tick();
        end
        check("r2_no_err_pulse", 32'(seen), 0);

        // inf + -inf, qnan never arrives -> timeout rule 4
        do_reset();
        issue(3'd0, 32'h7F80_0000, 32'hFF80_0000);
        ticks(9);
        check("r4_no_early_pulse", 32'(a_err_pulse), 0);
        tick();
        check("r4_err_pulse", 32'(a_err_pulse), 1);
        check("r4_err_rule",  32'(a_err_rule), 4);
        check("r4_err_count", 32'(a_err_count), 1);
        check("r4_sticky",    32'(a_sticky_err), 1);
        tick();
        check("r4_pulse_one_cycle", 32'(a_err_pulse), 0);
        check("r4_busy_low",        32'(a_busy), 0);

        // inf + inf, inf only at age 1 -> early flag ignored, timeout rule 5
        do_reset();
        issue(3'd0, 32'h7F80_0000, 32'h7F80_0000);
        flags = 8'h01;
        tick();
        flags = 8'h00;
        ticks(9);
        check("r5_err_pulse",  32'(a_err_pulse), 1);
        check("r5_err_rule",   32'(a_err_rule), 5);
        check("r5_pass_count", 32'(a_pass_count), 0);

        // inf * 2.0, inf exactly at age WIN_MAX -> pass
        do_reset();
        issue(3'd2, 32'h7F80_0000, 32'h4000_0000);
        ticks(9);
        flags = 8'h01;
        tick();
        flags = 8'h00;
        check("r8_edge_pass",     32'(a_pass_count), 1);
        check("r8_edge_no_pulse", 32'(a_err_pulse), 0);
        check("r8_edge_count",    32'(a_err_count), 0);

        // NaN operand and en low never enqueue
        do_reset();
        issue(3'd0, 32'h7FC0_0000, 32'h7F80_0000);
        check("nan_not_busy", 32'(a_busy), 0);
        en = 1'b0;
        issue(3'd3, 32'h3F80_0000, 32'h0000_0000);
        en = 1'b1;
        check("en_low_not_busy", 32'(a_busy), 0);

        // 6 back-to-back 0*2.0 into 4 slots -> 2 drops, then 4 timeouts
        do_reset();
        in_valid = 1'b1; fpu_op = 3'd2; opa = 32'h0000_0000; opb = 32'h4000_0000;
        ticks(6);
        in_valid = 1'b0;
        check("d4_drop_count", 32'(b_drop_count), 2);
        check("d12_drop_count", 32'(a_drop_count), 0);
        ticks(5);
        for (int k = 1; k <= 4; k++) begin
            check("d4_timeout_pulse", 32'(b_err_pulse), 1);
            check("d4_timeout_count", 32'(b_err_count), 32'(k));
            tick();
        end
        check("d4_pulse_done", 32'(b_err_pulse), 0);
        check("d4_busy_low",   32'(b_busy), 0);
        check("d4_err_rule",   32'(b_err_rule), 10);

        // overflow+underflow together for 3 cycles
        do_reset();
        flags = 8'h30;
        tick();
        check("r13_first_pulse", 32'(a_err_pulse), 1);
        ticks(2);
        flags = 8'h00;
        check("r13_err_rule",  32'(a_err_rule), 13);
        check("r13_err_count", 32'(a_err_count), 3);
        tick();
        check("r13_pulse_done", 32'(a_err_pulse), 0);
        check("r13_rule_holds", 32'(a_err_rule), 13);

        // timeout and rule 13 in the same cycle
        do_reset();
        issue(3'd0, 32'h7F80_0000, 32'hFF80_0000);
        ticks(9);
        flags = 8'h30;
        tick();
        flags = 8'h00;
        check("both_err_count", 32'(a_err_count), 2);
        check("both_err_rule",  32'(a_err_rule), 4);

        // rst at age 5 drops the tracked sub with no violation
        do_reset();
        issue(3'd1, 32'h4120_0000, 32'h4120_0000);
        check("r12_busy", 32'(a_busy), 1);
        ticks(4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            seen = seen | a_err_pulse;
            tick();
        end
        check("rst_no_pulse",  32'(seen), 0);
        check("rst_busy",      32'(a_busy), 0);
        check("rst_err_count", 32'(a_err_count), 0);
        check("rst_sticky",    32'(a_sticky_err), 0);
        check("rst_err_rule",  32'(a_err_rule), 0);

        // counter saturation on the 4-bit instance
        do_reset();
        flags = 8'h30;
        ticks(20);
        flags = 8'h00;
        check("sat_b_err_count", 32'(b_err_count), 15);
        check("sat_a_err_count", 32'(a_err_count), 20);
        do_reset();
        check("sat_cleared", 32'(b_err_count), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
